mem_port_arbiter: RTL and testbench

- Sequences a single-ported unified instruction/data memory for the 5-stage pipelined RV32I core.
- Two requesters share the port: F-stage instruction fetch and M-stage load/store.
- Serialises accesses through a request/acknowledge memory handshake with variable latency.
- Drives per-requester stalls so the hazard logic can freeze the pipeline while an access is pending.

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one request/acknowledge memory port between the RV32I
// fetch stage and the load/store stage, with a starvation guard and a timeout.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [2:0]  dm_mode_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_valid_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_mode_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int            WW        = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [2:0]    MODE_WORD = 3'b010;
  localparam logic [31:0]   NOP_INSN  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_cnt_nxt;
  logic          req_nxt;
  logic          we_nxt;
  logic [2:0]    mode_nxt;
  logic [31:0]   addr_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   if_rdata_nxt;
  logic [31:0]   dm_rdata_nxt;
  logic          if_valid_nxt;
  logic          dm_valid_nxt;
  logic          err_nxt;
  logic          fetch_first;
  logic          tmo_hit;

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    if (v == WAIT_MAX) begin
      return v;
    end else begin
      return v + WW'(1);
    end
  endfunction

  // Fetch overrides data priority once it has lost MAX_WAIT arbitrations in a row
  assign fetch_first = if_req_i && (wait_cnt == WAIT_MAX);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign if_stall_o  = if_req_i && !if_valid_o;
  assign dm_stall_o  = dm_req_i && !dm_valid_o;

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    req_nxt      = mem_req_o;
    we_nxt       = mem_we_o;
    mode_nxt     = mem_mode_o;
    addr_nxt     = mem_addr_o;
    wdata_nxt    = mem_wdata_o;
    if_rdata_nxt = if_rdata_o;
    dm_rdata_nxt = dm_rdata_o;
    if_valid_nxt = 1'b0;
    dm_valid_nxt = 1'b0;
    err_nxt      = err_o;
    case (state)
      IDLE: begin
        tmo_cnt_nxt = {CW{1'b0}};
        if (if_req_i && (!dm_req_i || fetch_first)) begin
          state_nxt    = BUSY_I;
          req_nxt      = 1'b1;
          we_nxt       = 1'b0;
          mode_nxt     = MODE_WORD;
          addr_nxt     = if_addr_i;
          wait_cnt_nxt = {WW{1'b0}};
        end else if (dm_req_i) begin
          state_nxt = BUSY_D;
          req_nxt   = 1'b1;
          we_nxt    = dm_we_i;
          mode_nxt  = dm_mode_i;
          addr_nxt  = dm_addr_i;
          wdata_nxt = dm_wdata_i;
          if (if_req_i) begin
            wait_cnt_nxt = sat_inc(wait_cnt);
          end else begin
            wait_cnt_nxt = wait_cnt;
          end
        end else begin
          req_nxt = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        tmo_cnt_nxt = tmo_cnt + CW'(1);
        // An ack in the timeout cycle still delivers real data
        if (mem_ack_i) begin
          state_nxt = RESP;
          req_nxt   = 1'b0;
          if (state == BUSY_I) begin
            if_rdata_nxt = mem_rdata_i;
            if_valid_nxt = 1'b1;
          end else begin
            dm_valid_nxt = 1'b1;
            if (!mem_we_o) begin
              dm_rdata_nxt = mem_rdata_i;
            end else begin
              dm_rdata_nxt = dm_rdata_o;
            end
          end
        end else if (tmo_hit) begin
          state_nxt = RESP;
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          if (state == BUSY_I) begin
            if_rdata_nxt = NOP_INSN;
            if_valid_nxt = 1'b1;
          end else begin
            dm_rdata_nxt = 32'h0000_0000;
            dm_valid_nxt = 1'b1;
          end
        end else begin
          state_nxt = state;
        end
      end
      RESP: begin
        state_nxt   = IDLE;
        tmo_cnt_nxt = {CW{1'b0}};
      end
      default: begin
        state_nxt   = IDLE;
        req_nxt     = 1'b0;
        tmo_cnt_nxt = {CW{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= {WW{1'b0}};
      tmo_cnt     <= {CW{1'b0}};
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_mode_o  <= 3'b000;
      mem_addr_o  <= 32'h0000_0000;
      mem_wdata_o <= 32'h0000_0000;
      if_rdata_o  <= 32'h0000_0000;
      dm_rdata_o  <= 32'h0000_0000;
      if_valid_o  <= 1'b0;
      dm_valid_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      mem_req_o   <= req_nxt;
      mem_we_o    <= we_nxt;
      mem_mode_o  <= mode_nxt;
      mem_addr_o  <= addr_nxt;
      mem_wdata_o <= wdata_nxt;
      if_rdata_o  <= if_rdata_nxt;
      dm_rdata_o  <= dm_rdata_nxt;
      if_valid_o  <= if_valid_nxt;
      dm_valid_o  <= dm_valid_nxt;
      err_o       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single-requester accesses plus hand-written
// reset, arbitration, starvation and late-ack sequences, checked through a scoreboard.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int TMO      = 8;
  localparam int NV       = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [2:0]  dm_mode_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_valid_o, if_stall_o, dm_valid_o, dm_stall_o;
  logic        mem_req_o, mem_we_o, err_o;
  logic [2:0]  mem_mode_o;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TMO), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_mode_i(dm_mode_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
    .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_mode_o(mem_mode_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] wdata;
    int          busy;
  } grant_t;

  typedef struct {
    logic        fetch;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] preload;
    int          delay;
    logic [2:0]  exp_mode;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  grant_t      grant_q[$];
  resp_t       resp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  logic        manual_ack = 1'b0;
  int          busy_cnt = 0;
  logic        prev_req = 1'b0;
  int          busy_seen = 0;
  grant_t      cur;
  resp_t       r;
  vec_t        vt [NV];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_grant(input logic [31:0] a, input logic we, input logic [2:0] m,
                            input logic [31:0] wd, input int busy);
    grant_t g;
    g.addr = a; g.we = we; g.mode = m; g.wdata = wd; g.busy = busy;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input logic f, input logic [31:0] rd, input logic e);
    resp_t x;
    x.fetch = f; x.rdata = rd; x.err = e;
    resp_q.push_back(x);
  endtask

  task automatic run_until_idle(input int budget, input int d_needed);
    int dcnt;
    int i;
    dcnt = 0;
    i = 0;
    while ((if_req_i || dm_req_i) && i < budget) begin
      tick();
      i++;
      if (if_valid_o) if_req_i = 1'b0;
      if (dm_valid_o) begin
        dcnt++;
        if (dcnt >= d_needed) dm_req_i = 1'b0;
      end
    end
    n_cmp++;
    if (if_req_i || dm_req_i) begin
      n_err++;
      $display("FAIL run_until_idle: requests still pending after %0d cycles, expected all served", budget);
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_mode", 32'(mem_mode_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    check("rst_if_valid", 32'(if_valid_o), 32'd0);
    check("rst_dm_valid", 32'(dm_valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
  endtask

  // Memory responder: acks after ack_delay BUSY cycles (0 = never); IDLE acks come from manual_ack
  always @(posedge clk) begin
    #2;
    if (mem_req_o) begin
      busy_cnt = busy_cnt + 1;
      if (busy_cnt == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_read(mem_addr_o);
        if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;
      end
    end else begin
      busy_cnt    = 0;
      mem_ack_i   = manual_ack;
      mem_rdata_i = 32'h1111_2222;
    end
  end

  // Scoreboard monitor: grants, BUSY stability/length, responses and stalls
  always @(negedge clk) begin
    check("if_stall", 32'(if_stall_o), 32'(if_req_i & ~if_valid_o));
    check("dm_stall", 32'(dm_stall_o), 32'(dm_req_i & ~dm_valid_o));
    check("valid_overlap", 32'(if_valid_o & dm_valid_o), 32'd0);
    if (mem_req_o && !prev_req) begin
      if (grant_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant: mem_req_o=1 addr=%h, expected no request", mem_addr_o);
        cur.addr = mem_addr_o; cur.we = mem_we_o; cur.mode = mem_mode_o;
        cur.wdata = mem_wdata_o; cur.busy = -1;
      end else begin
        cur = grant_q.pop_front();
      end
      busy_seen = 0;
    end
    if (mem_req_o) begin
      busy_seen++;
      check("grant_addr", mem_addr_o, cur.addr);
      check("grant_we", 32'(mem_we_o), 32'(cur.we));
      check("grant_mode", 32'(mem_mode_o), 32'(cur.mode));
      if (cur.we) check("grant_wdata", mem_wdata_o, cur.wdata);
    end else if (prev_req && cur.busy > 0) begin
      check("busy_cycles", 32'(busy_seen), 32'(cur.busy));
    end
    if (if_valid_o || dm_valid_o) begin
      if (resp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: if_valid=%0b dm_valid=%0b, expected no pulse", if_valid_o, dm_valid_o);
      end else begin
        r = resp_q.pop_front();
        check("resp_source", 32'(if_valid_o), 32'(r.fetch));
        check("resp_rdata", r.fetch ? if_rdata_o : dm_rdata_o, r.rdata);
        check("resp_err", 32'(err_o), 32'(r.err));
      end
    end
    prev_req = mem_req_o;
  end

  initial begin
    vec_t v;
    //        fetch we    mode    addr          wdata         pre   preload       dly exp_mode exp_rdata     err
    vt[0]  = '{1'b1, 1'b0, 3'b111, 32'h0000_0010, 32'h0,        1'b1, 32'h0050_0093, 1, 3'b010, 32'h0050_0093, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        1'b1, 32'h1234_5678, 1, 3'b010, 32'h1234_5678, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 32'h0,        2, 3'b010, 32'h1234_5678, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        1'b0, 32'h0,         3, 3'b000, 32'hCAFE_F00D, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0014, 32'h0,        1'b1, 32'hFFF0_0113, 5, 3'b010, 32'hFFF0_0113, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0204, 32'h0000_BEEF, 1'b0, 32'h0,        7, 3'b001, 32'hCAFE_F00D, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 3'b100, 32'h0000_0204, 32'h0,        1'b0, 32'h0,         8, 3'b100, 32'h0000_BEEF, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0018, 32'h0,        1'b1, 32'h0000_0073, 8, 3'b010, 32'h0000_0073, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_001C, 32'h0,        1'b0, 32'h0,         0, 3'b010, 32'h0000_0013, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h0,        1'b0, 32'h0,         0, 3'b010, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        1'b0, 32'h0,         2, 3'b010, 32'h1234_5678, 1'b1};

    rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0030;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_mode_i = 3'b010;
    dm_addr_i = 32'h0000_0040; dm_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    mem_model[32'h0000_0040] = 32'h1234_5678;

    // Reset with both requesters active: nothing granted, then data wins first
    tick();
    check_reset_outputs();
    tick();
    check_reset_outputs();
    ack_delay = 1;
    push_grant(32'h0000_0040, 1'b0, 3'b010, 32'h0, 1);
    push_grant(32'h0000_0030, 1'b0, 3'b010, 32'h0, 1);
    push_resp(1'b0, 32'h1234_5678, 1'b0);
    push_resp(1'b1, mem_read(32'h0000_0030), 1'b0);
    rst = 1'b1;
    run_until_idle(40, 1);
    tick();

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      if (v.pre) mem_model[v.addr] = v.preload;
      ack_delay = v.delay;
      push_grant(v.addr, v.fetch ? 1'b0 : v.we, v.exp_mode, v.wdata, (v.delay == 0) ? TMO : v.delay);
      push_resp(v.fetch, v.exp_rdata, v.exp_err);
      if (v.fetch) begin
        if_addr_i = v.addr;
        if_req_i  = 1'b1;
      end else begin
        dm_we_i    = v.we;
        dm_mode_i  = v.mode;
        dm_addr_i  = v.addr;
        dm_wdata_i = v.wdata;
        dm_req_i   = 1'b1;
      end
      run_until_idle(60, 1);
      tick();
    end

    // Ack arriving while IDLE must be ignored
    manual_ack = 1'b1;
    tick();
    tick();
    manual_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("late_ack_req", 32'(mem_req_o), 32'd0);
      check("late_ack_dm_rdata", dm_rdata_o, 32'h1234_5678);
      check("late_ack_err", 32'(err_o), 32'd1);
    end

    // Simultaneous store and fetch: data first, store leaves dm_rdata at its reset value
    do_reset();
    check("err_cleared", 32'(err_o), 32'd0);
    ack_delay = 2;
    push_grant(32'h0000_0100, 1'b1, 3'b010, 32'hCAFE_F00D, 2);
    push_grant(32'h0000_0020, 1'b0, 3'b010, 32'h0, 2);
    push_resp(1'b0, 32'h0000_0000, 1'b0);
    push_resp(1'b1, mem_read(32'h0000_0020), 1'b0);
    dm_we_i = 1'b1; dm_mode_i = 3'b010; dm_addr_i = 32'h0000_0100; dm_wdata_i = 32'hCAFE_F00D;
    if_addr_i = 32'h0000_0020;
    dm_req_i = 1'b1;
    if_req_i = 1'b1;
    run_until_idle(60, 1);
    tick();

    // Starvation: four data grants, then fetch forced through, then data again
    ack_delay = 1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      push_grant(32'h0000_0040, 1'b0, 3'b010, 32'h0, 1);
      push_resp(1'b0, mem_read(32'h0000_0040), 1'b0);
    end
    push_grant(32'h0000_0024, 1'b0, 3'b010, 32'h0, 1);
    push_resp(1'b1, mem_read(32'h0000_0024), 1'b0);
    push_grant(32'h0000_0040, 1'b0, 3'b010, 32'h0, 1);
    push_resp(1'b0, mem_read(32'h0000_0040), 1'b0);
    dm_we_i = 1'b0; dm_mode_i = 3'b010; dm_addr_i = 32'h0000_0040;
    if_addr_i = 32'h0000_0024;
    dm_req_i = 1'b1;
    if_req_i = 1'b1;
    run_until_idle(120, MAX_WAIT + 1);
    tick();

    // Reset in the middle of a fetch, then a fresh fetch completes
    ack_delay = 0;
    push_grant(32'h0000_0028, 1'b0, 3'b010, 32'h0, -1);
    if_addr_i = 32'h0000_0028;
    if_req_i = 1'b1;
    for (int i = 0; i < 10 && !mem_req_o; i++) tick();
    check("rst_mid_grant", 32'(mem_req_o), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_req", 32'(mem_req_o), 32'd0);
    check("rst_mid_if_valid", 32'(if_valid_o), 32'd0);
    ack_delay = 2;
    push_grant(32'h0000_0028, 1'b0, 3'b010, 32'h0, 2);
    push_resp(1'b1, mem_read(32'h0000_0028), 1'b0);
    rst = 1'b1;
    run_until_idle(40, 1);
    tick();
    tick();

    check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
